line_engine: RTL

- Responder end of the CPU's line-engine command interface.
- Captures endpoint coordinates and colour from the CPU's valid strobes. On a trigger, rasterises the line with Bresenham's algorithm.
- Emits one frame-buffer pixel write per drawn pixel over a valid/ready handshake to the memory arbiter.
- Reports idle to the CPU on line_ready.

---
 rtl/line_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/line_engine.sv
// line_engine
//   Responder end of the CPU line-engine command interface. Endpoint
//   coordinates and colour are latched from individual valid strobes while
//   the engine is idle; a trigger rasterises the line with Bresenham's
//   algorithm and emits one frame-buffer write per drawn pixel over a
//   valid/ready handshake.
//
//   Build option: define LINE_CLIP_EN to skip points outside H_RES x V_RES.
//   Skipped points are still walked, one cycle each with no write, so the
//   endpoint test keeps working for lines that leave the visible area.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   line_color        pixel colour, bits [23:0] are RGB
//   line_point        coordinate value carried by the x0/y0/x1/y1 strobes
//   line_*_valid      latch line_color / line_point into the named register
//   line_trigger      start drawing the latched line
//   line_ready        engine idle, strobes and trigger are accepted
//   px_addr           byte address of the pixel write
//   px_data           pixel data {8'h00, colour}
//   px_valid          pixel write request
//   px_ready          arbiter accepts the write this cycle
module line_engine #(
    parameter int          H_RES   = 800,
    parameter int          V_RES   = 600,
    parameter logic [31:0] FB_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] line_color,
    input  logic [9:0]  line_point,
    input  logic        line_color_valid,
    input  logic        line_x0_valid,
    input  logic        line_y0_valid,
    input  logic        line_x1_valid,
    input  logic        line_y1_valid,
    input  logic        line_trigger,
    output logic        line_ready,
    output logic [31:0] px_addr,
    output logic [31:0] px_data,
    output logic        px_valid,
    input  logic        px_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t state, state_next;

    // Command registers
    logic [9:0]  x0, y0, x1, y1;
    logic [23:0] colour;

    // Rasteriser state
    logic [9:0]         x, y;
    logic [10:0]        dx, dy;
    logic               sx_neg, sy_neg;
    logic signed [11:0] err;

    logic               in_bounds, on_screen, at_end, advance;
    logic               step_x, step_y;
    logic [10:0]        dx_init, dy_init;
    logic signed [11:0] err_init;
    logic signed [12:0] e2, dx_s, dy_s, err_ext, err_sum;

    // Colour bits above RGB carry nothing for the frame buffer.
    logic unused_colour_hi;
    assign unused_colour_hi = ^line_color[31:24];

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {1'b0, d};
    endfunction

    assign in_bounds = (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));

`ifdef LINE_CLIP_EN
    assign on_screen = in_bounds;
`else
    // Without clipping every point is written; the bounds are not consulted.
    logic unused_bounds;
    assign unused_bounds = in_bounds;
    assign on_screen     = 1'b1;
`endif

    assign at_end  = (x == x1) && (y == y1);
    // An off-screen point has no handshake, so it advances unconditionally.
    assign advance = (state == DRAW) && (!on_screen || px_ready);

    assign dx_init  = abs_diff(x1, x0);
    assign dy_init  = abs_diff(y1, y0);
    assign err_init = $signed({1'b0, dx_init}) - $signed({1'b0, dy_init});

    // Both step decisions use the error value from before this step.
    assign e2      = $signed({err, 1'b0});
    assign dx_s    = $signed({2'b00, dx});
    assign dy_s    = $signed({2'b00, dy});
    assign step_x  = e2 > -dy_s;
    assign step_y  = e2 < dx_s;
    assign err_ext = $signed({err[11], err});
    assign err_sum = err_ext - (step_x ? dy_s : 13'sd0) + (step_y ? dx_s : 13'sd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        line_ready = 1'b0;
        px_valid   = 1'b0;
        px_addr    = '0;
        px_data    = '0;
        unique case (state)
            IDLE: begin
                line_ready = 1'b1;
                if (line_trigger) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = DRAW;
            end
            DRAW: begin
                px_valid = on_screen;
                px_addr  = FB_BASE + {10'd0, y, x, 2'b00};
                px_data  = {8'h00, colour};
                if (advance && at_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture: only while idle, so a line in flight is never altered.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0     <= '0;
            y0     <= '0;
            x1     <= '0;
            y1     <= '0;
            colour <= '0;
        end else if (state == IDLE) begin
            if (line_x0_valid)    x0     <= line_point;
            if (line_y0_valid)    y0     <= line_point;
            if (line_x1_valid)    x1     <= line_point;
            if (line_y1_valid)    y1     <= line_point;
            if (line_color_valid) colour <= line_color[23:0];
        end
    end

    // Rasteriser datapath; only meaningful while SETUP/DRAW, so no reset.
    always_ff @(posedge clk) begin
        if (state == SETUP) begin
            dx     <= dx_init;
            dy     <= dy_init;
            sx_neg <= x1 < x0;
            sy_neg <= y1 < y0;
            err    <= err_init;
            x      <= x0;
            y      <= y0;
        end else if (advance && !at_end) begin
            if (step_x) x <= sx_neg ? (x - 10'd1) : (x + 10'd1);
            if (step_y) y <= sy_neg ? (y - 10'd1) : (y + 10'd1);
            err <= err_sum[11:0];
        end
    end

endmodule
